// File: rtl/uart_tx_pkg.sv
// Shared UART TX definitions: issue-FSM encoding plus the TX core's own state constants.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } issue_state_t;

  // TX core shift engine states; kept here so the core and the issue logic agree on encoding
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  localparam int TX_FRAME_BITS = 10;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered FULL/EMPTY/COUNT and a one-cycle overflow pulse.
module sync_fifo #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 16,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [AW:0]           count,
  output logic                  overflow
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count_nxt;
  logic                  wr_acc, rd_acc;

  assign wr_acc  = wr_en && !full;
  assign rd_acc  = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (wr_acc && !rd_acc)      count_nxt = count + (AW+1)'(1);
    else if (!wr_acc && rd_acc) count_nxt = count - (AW+1)'(1);
  end

  always_ff @(posedge CLK) begin
    if (wr_acc && !RST) mem[wr_ptr] <= wr_data;
  end

  // DEPTH is a power of two, so pointer wrap is plain binary rollover
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      count    <= count_nxt;
      full     <= (count_nxt == (AW+1)'(DEPTH));
      empty    <= (count_nxt == '0);
      overflow <= wr_en && full;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Character FIFO in front of a UART TX core: pops one entry per TX busy cycle and strobes it out.
module uart_tx_fifo
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    WR_DATA,
  input  logic                     WR_EN,
  output logic                     FULL,
  output logic                     EMPTY,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     OVERFLOW,
  output logic [DATA_WIDTH-1:0]    P_DATA,
  output logic                     DATA_VALID,
  input  logic                     BUSY
);

  issue_state_t          state;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head;

  // EMPTY is registered, so a write landing this cycle cannot be popped until the next
  assign pop = (state == IDLE) && !EMPTY && !BUSY;

  sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .CLK      (CLK),
    .RST      (RST),
    .wr_data  (WR_DATA),
    .wr_en    (WR_EN),
    .rd_en    (pop),
    .rd_data  (head),
    .full     (FULL),
    .empty    (EMPTY),
    .count    (COUNT),
    .overflow (OVERFLOW)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      DATA_VALID <= 1'b0;
      P_DATA     <= '0;
    end else begin
      DATA_VALID <= 1'b0;
      case (state)
        IDLE: if (pop) begin
          state      <= LAUNCH;
          P_DATA     <= head;
          DATA_VALID <= 1'b1;
        end
        LAUNCH:    state <= WAIT_BUSY;
        WAIT_BUSY: if (BUSY)  state <= WAIT_DONE;
        WAIT_DONE: if (!BUSY) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus pushes expected characters, a monitor checks launches.
module tb_uart_tx_fifo;
  import uart_tx_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          CLK = 1'b0;
  logic          RST, WR_EN, BUSY, FULL, EMPTY, OVERFLOW, DATA_VALID;
  logic [DW-1:0] WR_DATA, P_DATA;
  logic [CW-1:0] COUNT;

  logic          tx_auto, tx_busy, busy_force;
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] b2b [3] = '{8'h11, 8'h22, 8'h33};

  always #5 CLK = ~CLK;

  assign BUSY = tx_auto ? tx_busy : busy_force;

  uart_tx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .WR_DATA    (WR_DATA),
    .WR_EN      (WR_EN),
    .FULL       (FULL),
    .EMPTY      (EMPTY),
    .COUNT      (COUNT),
    .OVERFLOW   (OVERFLOW),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .BUSY       (BUSY)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (!(exp_q.size() == 0 && dut.state == IDLE && !BUSY && EMPTY) && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(n < budget), 1);
  endtask

  // TX core model: each launch holds BUSY high for 10 cycles
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge CLK);
      if (tx_auto && DATA_VALID) begin
        @(posedge CLK);
        #1 tx_busy = 1'b1;
        repeat (10) @(posedge CLK);
        #1 tx_busy = 1'b0;
      end
    end
  end

  // Monitor: every launch must match the next expected character and follow a BUSY-low cycle
  initial begin
    logic prev_busy;
    prev_busy = 1'b0;
    forever begin
      @(negedge CLK);
      if (DATA_VALID) begin
        if (exp_q.size() == 0) chk("unexpected_launch", 32'(DATA_VALID), 0);
        else                   chk("p_data_order", 32'(P_DATA), 32'(exp_q.pop_front()));
        chk("busy_low_at_pop", 32'(prev_busy), 0);
      end
      prev_busy = BUSY;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int i, n, dv_seen;
    RST = 1'b1; WR_EN = 1'b0; WR_DATA = '0; tx_auto = 1'b1; busy_force = 1'b0;
    tick(); tick();
    @(negedge CLK);
    chk("rst_empty", 32'(EMPTY), 1);
    chk("rst_full", 32'(FULL), 0);
    chk("rst_count", 32'(COUNT), 0);
    chk("rst_overflow", 32'(OVERFLOW), 0);
    chk("rst_dv", 32'(DATA_VALID), 0);
    chk("rst_pdata", 32'(P_DATA), 0);
    tick();
    RST = 1'b0;
    tick();

    // single character latency
    WR_DATA = 8'hA5; WR_EN = 1'b1; exp_q.push_back(8'hA5);
    @(negedge CLK); chk("lat_c0_dv", 32'(DATA_VALID), 0);
    tick(); WR_EN = 1'b0;
    @(negedge CLK); chk("lat_c1_dv", 32'(DATA_VALID), 0); chk("lat_c1_count", 32'(COUNT), 1);
    @(negedge CLK);
    chk("lat_c2_dv", 32'(DATA_VALID), 1);
    chk("lat_c2_pdata", 32'(P_DATA), 32'h A5);
    chk("lat_c2_count", 32'(COUNT), 0);
    wait_drain("drain_a5", 100);

    // back-to-back with busy TX core
    for (int k = 0; k < 3; k++) begin
      WR_DATA = b2b[k]; WR_EN = 1'b1; exp_q.push_back(b2b[k]);
      tick();
    end
    WR_EN = 1'b0;
    wait_drain("b2b_drain", 300);

    // fill with BUSY held high, then overflow
    tx_auto = 1'b0; busy_force = 1'b1;
    for (int k = 0; k < 16; k++) begin
      WR_DATA = DW'(8'h40 + k); WR_EN = 1'b1; exp_q.push_back(DW'(8'h40 + k));
      tick();
    end
    WR_DATA = 8'h50; WR_EN = 1'b1;
    @(negedge CLK);
    chk("fill_full", 32'(FULL), 1);
    chk("fill_count", 32'(COUNT), 16);
    chk("fill_no_ovf", 32'(OVERFLOW), 0);
    tick(); WR_EN = 1'b0;
    @(negedge CLK);
    chk("ovf_pulse", 32'(OVERFLOW), 1);
    chk("ovf_count", 32'(COUNT), 16);
    chk("ovf_full", 32'(FULL), 1);
    tick();
    @(negedge CLK); chk("ovf_single", 32'(OVERFLOW), 0);

    // release BUSY and write in the pop cycle while still full
    tick();
    WR_DATA = 8'h99; WR_EN = 1'b1; tx_auto = 1'b1;
    @(negedge CLK); chk("popcyc_full", 32'(FULL), 1);
    tick(); WR_EN = 1'b0;
    @(negedge CLK);
    chk("popcyc_count", 32'(COUNT), 15);
    chk("popcyc_ovf", 32'(OVERFLOW), 1);
    chk("popcyc_notfull", 32'(FULL), 0);
    wait_drain("full_drain", 600);

    // 40-character stream across pointer wrap
    i = 0; n = 0;
    while (i < 40 && n < 2000) begin
      if (!FULL) begin
        WR_DATA = DW'(i); WR_EN = 1'b1; exp_q.push_back(DW'(i)); i++;
      end else WR_EN = 1'b0;
      tick();
      n++;
    end
    WR_EN = 1'b0;
    chk("stream_issued", 32'(i), 40);
    wait_drain("stream_drain", 1000);

    // reset during WAIT_DONE with 5 queued
    for (int k = 0; k < 6; k++) begin
      WR_DATA = DW'(8'hC0 + k); WR_EN = 1'b1; exp_q.push_back(DW'(8'hC0 + k));
      tick();
    end
    WR_EN = 1'b0;
    n = 0;
    while (!(dut.state == WAIT_DONE && COUNT == 5) && n < 50) begin
      tick();
      n++;
    end
    chk("reach_wait_done", 32'(n < 50), 1);
    chk("queued_before_rst", 32'(exp_q.size()), 5);
    RST = 1'b1; WR_EN = 1'b1; WR_DATA = 8'hEE;
    tick();
    RST = 1'b0; WR_EN = 1'b0;
    exp_q.delete();
    @(negedge CLK);
    chk("midrst_empty", 32'(EMPTY), 1);
    chk("midrst_count", 32'(COUNT), 0);
    chk("midrst_idle", 32'(dut.state == IDLE), 1);
    chk("midrst_dv", 32'(DATA_VALID), 0);
    chk("midrst_pdata", 32'(P_DATA), 0);
    dv_seen = 0;
    repeat (30) begin
      tick();
      if (DATA_VALID) dv_seen++;
    end
    chk("midrst_no_dv", 32'(dv_seen), 0);
    WR_DATA = 8'h77; WR_EN = 1'b1; exp_q.push_back(8'h77);
    tick();
    WR_EN = 1'b0;
    wait_drain("post_rst_drain", 200);

    chk("queue_empty_end", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of one UART character.
REQ-002 Parameter DEPTH, default 16, FIFO entries; SHALL be a power of two and at least 2.
REQ-003 CLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 RST  input  1  reset; synchronous, active-high.
REQ-005 WR_DATA  input  DATA_WIDTH  character to enqueue.
REQ-006 WR_EN  input  1  enqueue request; sampled each cycle.
REQ-007 FULL  output  1  FIFO holds DEPTH entries.
REQ-008 EMPTY  output  1  FIFO holds 0 entries.
REQ-009 COUNT  output  $clog2(DEPTH)+1  current occupancy.
REQ-010 OVERFLOW  output  1  one-cycle pulse when a write is dropped.
REQ-011 P_DATA  output  DATA_WIDTH  character presented to the downstream UART TX core.
REQ-012 DATA_VALID  output  1  one-cycle launch strobe to the TX core.
REQ-013 BUSY  input  1  TX core busy: low only while the core is idle.

Function
REQ-014 A write SHALL be accepted when WR_EN=1 and FULL=0; WR_DATA is stored at the write pointer and the pointer advances modulo DEPTH.
REQ-015 When WR_EN=1 and FULL=1, the write SHALL be dropped, storage and pointers SHALL be unchanged, and OVERFLOW SHALL pulse high the next cycle.
REQ-016 FULL, EMPTY and COUNT SHALL be registered and reflect occupancy after the previous edge.
REQ-017 Same-cycle accepted write and pop SHALL leave COUNT unchanged; write-only SHALL increment it; pop-only SHALL decrement it.
REQ-018 Pointers SHALL wrap from DEPTH-1 to 0 with no lost or duplicated entries.
REQ-019 The issue FSM SHALL have four states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
REQ-020 IDLE -> LAUNCH when EMPTY=0 and BUSY=0; this is the pop cycle: the head entry is registered into P_DATA and the read pointer advances.
REQ-021 LAUNCH SHALL last exactly one cycle with DATA_VALID=1, then go to WAIT_BUSY; DATA_VALID SHALL be 0 in every other state.
REQ-022 WAIT_BUSY -> WAIT_DONE when BUSY=1; otherwise stay.
REQ-023 WAIT_DONE -> IDLE when BUSY=0; otherwise stay.
REQ-024 P_DATA SHALL hold its value from LAUNCH until the next pop.
REQ-025 Latency: a write into an empty FIFO with the FSM idle and BUSY=0 SHALL give DATA_VALID=1 exactly 2 cycles after the WR_EN edge.
REQ-026 Back-to-back characters SHALL give at most one DATA_VALID per BUSY high-to-low cycle of the TX core; no character SHALL be launched while BUSY=1.
REQ-027 A write landing in an empty FIFO in the same cycle the FSM is in IDLE SHALL NOT be popped in that cycle, because EMPTY is registered.

Reset
REQ-028 While RST=1 at a clock edge: pointers=0, COUNT=0, EMPTY=1, FULL=0, OVERFLOW=0, DATA_VALID=0, P_DATA=0, FSM=IDLE.
REQ-029 Reset asserted mid-operation SHALL discard all stored entries and abandon any launch in progress; WR_EN during reset SHALL be ignored.
REQ-030 Storage array contents need not be reset.

Structure
REQ-031 The issue-FSM state encoding SHALL reside in a shared package uart_tx_pkg, alongside the TX core state constants.
REQ-032 The storage and pointer logic SHALL be one sub-module, sync_fifo, instantiated once; the issue FSM SHALL reside in uart_tx_fifo.

Verification
REQ-033 Reset, write 0xA5 with BUSY=0 -> DATA_VALID pulses 2 cycles later with P_DATA=0xA5, COUNT returns to 0.
REQ-034 Write 0x11, 0x22, 0x33 back-to-back while a TX model holds BUSY high 10 cycles per character -> three DATA_VALID pulses in order 0x11, 0x22, 0x33, each only after BUSY falls.
REQ-035 Write 17 characters with BUSY held at 1 -> FULL=1 after the 16th write, OVERFLOW pulses once, COUNT=16, and the 17th value is never transmitted.
REQ-036 With FULL=1, release BUSY and write in the pop cycle -> write dropped, COUNT=15 afterwards.
REQ-037 Stream 40 characters 0x00..0x27 through DEPTH=16 -> output order exact across pointer wrap.
REQ-038 Assert RST in WAIT_DONE with 5 entries queued -> next cycle EMPTY=1, COUNT=0, FSM=IDLE, and no DATA_VALID until a new write.
